// File: rtl/seg7_mux_driver.sv
// Multiplexed seven-segment display driver: scans NUM_DIGITS digits over a
// shared segment bus. It supports hex/decimal decode, leading-zero blanking,
// per-digit decimal points and frame-synchronous (tear-free) value update.
module seg7_mux_driver #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned CLK_DIV    = 100000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    hex_mode,
  input  logic                    lz_blank,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned VW = 4 * NUM_DIGITS;
  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [VW-1:0]         pend_val;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic [VW-1:0]         disp_val;
  logic [NUM_DIGITS-1:0] disp_dp;

  logic                  tick_c;
  logic                  wrap_c;
  logic [3:0]            cur_nib_c;
  logic                  cur_dp_c;
  logic                  cur_lz_c;
  logic                  lz_run_c;
  logic [6:0]            pat_c;
  logic [NUM_DIGITS-1:0] an_pat_c;

  // Active-high segment pattern; nibbles 10..15 go blank outside hex mode.
  function automatic logic [6:0] decode(input logic [3:0] nib, input logic hex);
    logic [6:0] p;
    case (nib)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
      4'hA: p = 7'h77;
      4'hB: p = 7'h7C;
      4'hC: p = 7'h39;
      4'hD: p = 7'h5E;
      4'hE: p = 7'h79;
      default: p = 7'h71;
    endcase
    if (!hex && (nib > 4'd9)) p = 7'h00;
    return p;
  endfunction

  assign tick_c = (presc == PW'(CLK_DIV - 1));
  assign wrap_c = tick_c && (idx == IW'(NUM_DIGITS - 1));

  // Select the active digit and work out whether it is a leading zero.
  // The scan goes from the most significant digit down, so lz_run stays set
  // only while every nibble seen so far is zero.
  always_comb begin
    cur_nib_c = 4'h0;
    cur_dp_c  = 1'b0;
    cur_lz_c  = 1'b0;
    lz_run_c  = 1'b1;
    an_pat_c  = '0;
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      lz_run_c = lz_run_c && (disp_val[4*k +: 4] == 4'h0);
      an_pat_c[k] = (idx == IW'(k));
      if (idx == IW'(k)) begin
        cur_nib_c = disp_val[4*k +: 4];
        cur_dp_c  = disp_dp[k];
        cur_lz_c  = lz_run_c && (k != 0);
      end
    end
    pat_c = decode(cur_nib_c, hex_mode);
    if (lz_blank && cur_lz_c) pat_c = 7'h00;
  end

  // Refresh prescaler and digit scan counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
    end else if (tick_c) begin
      presc <= '0;
      idx   <= wrap_c ? '0 : idx + IW'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Pending buffer captures on load. The display buffer changes only at a
  // wrap, and a load on the wrap cycle itself goes straight to the display.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_val <= '0;
      pend_dp  <= '0;
      disp_val <= '0;
      disp_dp  <= '0;
    end else begin
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp_in;
      end
      if (wrap_c) begin
        disp_val <= load ? value : pend_val;
        disp_dp  <= load ? dp_in : pend_dp;
      end
    end
  end

  // Registered pin drivers, with polarity applied here.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg        <= {7{ACTIVE_LOW}};
      dp         <= ACTIVE_LOW;
      an         <= {NUM_DIGITS{ACTIVE_LOW}};
      frame_done <= 1'b0;
    end else begin
      seg        <= pat_c ^ {7{ACTIVE_LOW}};
      dp         <= cur_dp_c ^ ACTIVE_LOW;
      an         <= an_pat_c ^ {NUM_DIGITS{ACTIVE_LOW}};
      frame_done <= wrap_c;
    end
  end

endmodule
